// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response pair.
// Fixed-latency responder: one outstanding access, error on misaligned/out-of-range.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT =
    ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic        capWr;
  logic [31:0] capAddr;
  logic [31:0] capWdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enterResp;
  logic          srcWr;
  logic [31:0]   srcAddr;
  logic [31:0]   srcWdata;
  logic          srcErr;
  logic [AW-1:0] srcIdx;
  logic [31:0]   srcRdata;
  logic          memWe;

  // With zero wait the access completes on the accept edge,
  // so the live request fields feed the memory directly.
  always_comb begin
    accept    = (state == S_IDLE) && req_valid;
    srcWr     = accept ? req_wr    : capWr;
    srcAddr   = accept ? req_addr  : capAddr;
    srcWdata  = accept ? req_wdata : capWdata;
    srcErr    = (srcAddr[1:0] != 2'b00) ||
                (srcAddr[31:2] >= DEPTH_LIM);
    srcIdx    = srcAddr[AW+1:2];
    enterResp = (accept && ZERO_WAIT) ||
                ((state == S_WAIT) && (waitCnt == 4'd0));
    srcRdata  = (srcWr || srcErr) ? 32'd0 : mem[srcIdx];
    memWe     = rst_n && enterResp && srcWr && !srcErr;
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[srcIdx] <= srcWdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      waitCnt    <= 4'd0;
      capWr      <= 1'b0;
      capAddr    <= 32'd0;
      capWdata   <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            capWr     <= req_wr;
            capAddr   <= req_addr;
            capWdata  <= req_wdata;
            req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= srcRdata;
              resp_err   <= srcErr;
            end else begin
              state   <= S_WAIT;
              waitCnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (waitCnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= srcRdata;
            resp_err   <= srcErr;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
